mem_port_arbiter: RTL

//  Round-robin arbiter that shares one 32-bit data-memory port between four requesters.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between four requesters.
// Grants are locked until the owner's last beat, abandonment, or a watchdog release.
module mem_port_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] last,
    input  logic            mem_ready,
    output logic [NREQ-1:0] grant,
    output logic [1:0]      mux_sel,
    output logic            mem_valid,
    output logic            busy,
    output logic            timeout_err
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [1:0]        mux_sel_q, mux_sel_d;
    logic              busy_q, busy_d;
    logic              timeout_err_q, timeout_err_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic [NREQ-1:0]   arb_req;
    logic [1:0]        arb_start;
    logic [1:0]        arb_idx;
    logic [1:0]        cand;
    logic              arb_found;
    logic              beat;
    logic              watchdog;
    logic              release_now;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            mux_sel_q     <= 2'd0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            rr_ptr_q      <= 2'd0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            mux_sel_q     <= mux_sel_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        mux_sel_d     = mux_sel_q;
        busy_d        = busy_q;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_err_d = 1'b0;
        beat          = 1'b0;
        watchdog      = 1'b0;
        release_now   = 1'b0;
        arb_req       = req;
        arb_start     = rr_ptr_q;
        cand          = 2'd0;

        // On release the search starts after the owner and excludes it
        if (state_q == GRANT) begin
            beat        = mem_valid && mem_ready;
            watchdog    = req[mux_sel_q] && !beat && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
            release_now = (beat && last[mux_sel_q]) || !req[mux_sel_q] || watchdog;
            arb_req     = req & ~grant_q;
            arb_start   = mux_sel_q + 2'd1;
        end

        arb_found = 1'b0;
        arb_idx   = arb_start;
        for (int i = 3; i >= 0; i--) begin
            cand = arb_start + 2'(i);
            if (arb_req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end

        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (arb_found) begin
                    state_d   = GRANT;
                    grant_d   = NREQ'(1) << arb_idx;
                    mux_sel_d = arb_idx;
                    busy_d    = 1'b1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    rr_ptr_d      = mux_sel_q + 2'd1;
                    hold_cnt_d    = '0;
                    timeout_err_d = watchdog;
                    if (arb_found) begin
                        grant_d   = NREQ'(1) << arb_idx;
                        mux_sel_d = arb_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                    end
                end else if (beat) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != {CNT_W{1'b1}}) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_valid = (state_q == GRANT) && req[mux_sel_q];
    end

    assign grant       = grant_q;
    assign mux_sel     = mux_sel_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule
